// File: rtl/if_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl_pkg
// Description : Shared types and constants for the instruction fetch controller.
// Revision    : 1.0
// ============================================================================
package if_fetch_ctrl_pkg;

    localparam int unsigned      c_XLEN     = 32;
    localparam logic [c_XLEN-1:0] c_RESET_PC = '0;
    localparam logic [c_XLEN-1:0] c_PC_STEP  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SKID  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [c_XLEN-1:0] instr;
        logic [c_XLEN-1:0] pc;
    } slot_t;

    // Word-addressed increment; wraps naturally at 2^32.
    function automatic logic [c_XLEN-1:0] pc_incr(input logic [c_XLEN-1:0] a);
        return a + c_PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl_if
// Description : Fetch controller bus: decode/execute controls, imem port, IF slot.
// Revision    : 1.0
// ============================================================================
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic              freeze;
    logic              branch_taken;
    logic [c_XLEN-1:0] branch_addr;
    logic              imem_req;
    logic [c_XLEN-1:0] imem_addr;
    logic              imem_ready;
    logic [c_XLEN-1:0] imem_rdata;
    logic              if_valid;
    logic [c_XLEN-1:0] instruction;
    logic [c_XLEN-1:0] pc;
    logic              flush_id;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_valid, instruction, pc, flush_id
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_valid, instruction, pc, flush_id
    );

endinterface
`default_nettype wire

// File: rtl/if_fetch_ctrl_skid.sv
`default_nettype none
// ============================================================================
// Module      : if_skid_buf
// Description : One-entry holding buffer for a fetch response the slot cannot take.
// Revision    : 1.0
// ============================================================================
module if_skid_buf
    import if_fetch_ctrl_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  i_load,
    input  wire logic  i_unload,
    input  wire logic  i_clear,
    input  wire slot_t i_data,
    output logic       o_valid,
    output slot_t      o_data
);

    logic  r_valid;
    slot_t r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction fetch controller with skid buffer and branch redirect.
// Revision    : 1.0
// ============================================================================
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    if_fetch_ctrl_if.master bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;

    logic [c_XLEN-1:0] r_fetch_pc;
    logic [c_XLEN-1:0] r_addr;
    logic              r_req;
    logic              r_if_valid;
    logic              r_flush;
    slot_t             r_slot;

    logic              w_slot_free;
    logic              w_bus_free;
    logic              w_resp;
    logic              w_slot_load;
    logic              w_skid_load;
    logic              w_skid_unload;
    logic              w_issue;
    logic [c_XLEN-1:0] w_fetch_pc_nxt;
    slot_t             w_resp_entry;
    logic              w_skid_valid;
    slot_t             w_skid_data;

    assign w_slot_free  = !r_if_valid || !bus.freeze;
    // The request is registered: it was decided a cycle earlier, so a freeze
    // arriving with the response is exactly what the skid entry absorbs.
    assign w_bus_free   = !r_req || bus.imem_ready;
    assign w_resp_entry = '{instr: bus.imem_rdata, pc: pc_incr(r_addr)};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_state_nxt = r_state;
        if (bus.branch_taken) begin
            w_state_nxt = w_bus_free ? ST_FETCH : ST_DROP;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_FETCH;
                ST_FETCH: if (r_req && bus.imem_ready && !w_slot_free) w_state_nxt = ST_SKID;
                ST_SKID:  if (w_slot_free) w_state_nxt = ST_FETCH;
                ST_DROP:  if (bus.imem_ready) w_state_nxt = ST_FETCH;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        w_resp        = r_req && bus.imem_ready;
        w_slot_load   = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_issue       = 1'b0;
        if (bus.branch_taken) begin
            w_issue = w_bus_free;
        end else begin
            case (r_state)
                ST_IDLE: w_issue = 1'b1;
                ST_FETCH: begin
                    w_slot_load = w_resp && w_slot_free;
                    w_skid_load = w_resp && !w_slot_free;
                    w_issue     = w_bus_free && w_slot_free;
                end
                ST_SKID: w_skid_unload = w_skid_valid && w_slot_free;
                ST_DROP: w_issue = bus.imem_ready;
                default: w_issue = 1'b0;
            endcase
        end

        if (bus.branch_taken) begin
            w_fetch_pc_nxt = bus.branch_addr;
        end else if (w_slot_load || w_skid_load) begin
            w_fetch_pc_nxt = pc_incr(r_addr);
        end else begin
            w_fetch_pc_nxt = r_fetch_pc;
        end
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= c_RESET_PC;
            r_addr     <= '0;
            r_req      <= 1'b0;
            r_if_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_slot     <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_flush    <= bus.branch_taken;
            r_req      <= w_issue || (r_req && !bus.imem_ready);
            if (w_issue) begin
                r_addr <= w_fetch_pc_nxt;
            end

            if (bus.branch_taken) begin
                r_if_valid <= 1'b0;
            end else if (w_slot_load) begin
                r_if_valid <= 1'b1;
                r_slot     <= w_resp_entry;
            end else if (w_skid_unload) begin
                r_if_valid <= 1'b1;
                r_slot     <= w_skid_data;
            end else if (w_slot_free) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (bus.branch_taken),
        .i_data   (w_resp_entry),
        .o_valid  (w_skid_valid),
        .o_data   (w_skid_data)
    );

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_addr;
    assign bus.if_valid    = r_if_valid;
    assign bus.instruction = r_slot.instr;
    assign bus.pc          = r_slot.pc;
    assign bus.flush_id    = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_ctrl
// Description : Directed self-checking bench for if_fetch_ctrl.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_auto;
    logic        man_ready;
    logic [31:0] man_rdata;
    int          n_cmp = 0;
    int          n_err = 0;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Echo memory returns the word address as data, always ready.
    assign bus.imem_ready = mem_auto ? 1'b1 : man_ready;
    assign bus.imem_rdata = mem_auto ? bus.imem_addr : man_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        check_eq({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
        check_eq({tag, "_instr"}, bus.instruction, instr);
        check_eq({tag, "_pc"}, bus.pc, pc);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, "_req"}, 32'(bus.imem_req), 32'(req));
        if (req) check_eq({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_req"},   32'(bus.imem_req), 32'd0);
        check_eq({tag, "_addr"},  bus.imem_addr, 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
        check_eq({tag, "_instr"}, bus.instruction, 32'd0);
        check_eq({tag, "_pc"},    bus.pc, 32'd0);
        check_eq({tag, "_flush"}, 32'(bus.flush_id), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_auto = 1'b1; man_ready = 1'b0; man_rdata = '0;
        bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;
        tick(); tick(); tick();
        check_reset("rst_init");

        // Streaming from reset: cycle 0 is IDLE, slot fills from cycle 2.
        rst = 1'b0;
        #1 check_eq("idle_req", 32'(bus.imem_req), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_req("seq", 1'b1, 32'(c - 1));
            check_eq("seq_valid", 32'(bus.if_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check_eq("seq_instr", bus.instruction, 32'(c - 2));
                check_eq("seq_pc", bus.pc, 32'(c - 1));
            end
        end

        // Freeze for three cycles with the slot full; in-flight word goes to skid.
        bus.freeze = 1'b1;
        tick(); check_slot("frz1", 32'd3, 32'd4); check_req("frz1", 1'b0, 32'd0);
        tick(); check_slot("frz2", 32'd3, 32'd4); check_req("frz2", 1'b0, 32'd0);
        tick(); bus.freeze = 1'b0;
        check_slot("frz3", 32'd3, 32'd4); check_req("frz3", 1'b0, 32'd0);
        tick(); check_slot("unskid", 32'd4, 32'd5); check_req("unskid", 1'b0, 32'd0);
        tick(); check_eq("refetch_valid", 32'(bus.if_valid), 32'd0); check_req("refetch", 1'b1, 32'd5);
        tick(); check_slot("resume", 32'd5, 32'd6); check_req("resume", 1'b1, 32'd6);

        // Slow memory; branch to 0x100 while the request to 6 is pending.
        mem_auto = 1'b0; man_ready = 1'b0;
        tick(); bus.branch_taken = 1'b1; bus.branch_addr = 32'h100;
        check_req("wait1", 1'b1, 32'd6); check_eq("wait1_flush", 32'(bus.flush_id), 32'd0);
        tick(); bus.branch_taken = 1'b0;
        check_req("drop1", 1'b1, 32'd6); check_eq("drop1_flush", 32'(bus.flush_id), 32'd1);
        check_eq("drop1_valid", 32'(bus.if_valid), 32'd0);
        tick(); check_req("drop2", 1'b1, 32'd6); check_eq("drop2_flush", 32'(bus.flush_id), 32'd0);
        check_eq("drop2_valid", 32'(bus.if_valid), 32'd0);
        tick(); man_ready = 1'b1; man_rdata = 32'hDEAD_BEEF;
        check_req("drop3", 1'b1, 32'd6); check_eq("drop3_valid", 32'(bus.if_valid), 32'd0);
        tick(); man_rdata = 32'h0000_1234;
        check_req("tgt", 1'b1, 32'h100); check_eq("tgt_valid", 32'(bus.if_valid), 32'd0);
        tick(); check_slot("tgt_slot", 32'h1234, 32'h101); check_req("tgt_next", 1'b1, 32'h101);

        // Branch coinciding with a response while frozen.
        bus.freeze = 1'b1; man_rdata = 32'h0000_0BAD;
        bus.branch_taken = 1'b1; bus.branch_addr = 32'h200;
        tick(); bus.branch_taken = 1'b0; bus.freeze = 1'b0; man_ready = 1'b0;
        check_eq("brr_valid", 32'(bus.if_valid), 32'd0); check_eq("brr_flush", 32'(bus.flush_id), 32'd1);
        check_req("brr", 1'b1, 32'h200);
        tick(); man_ready = 1'b1; man_rdata = 32'h0000_2222;
        check_req("brr_wait", 1'b1, 32'h200); check_eq("brr_wait_valid", 32'(bus.if_valid), 32'd0);
        tick(); check_slot("brr_slot", 32'h2222, 32'h201); check_req("brr_next", 1'b1, 32'h201);

        // Wrap of the word address.
        bus.branch_taken = 1'b1; bus.branch_addr = 32'hFFFF_FFFF; man_rdata = 32'h0000_9999;
        tick(); bus.branch_taken = 1'b0; man_rdata = 32'h0000_5555;
        check_req("wrap", 1'b1, 32'hFFFF_FFFF); check_eq("wrap_flush", 32'(bus.flush_id), 32'd1);
        tick(); check_slot("wrap_slot", 32'h5555, 32'h0); check_req("wrap_next", 1'b1, 32'h0);
        check_eq("wrap_flush_off", 32'(bus.flush_id), 32'd0);

        // Reset during an outstanding request; ready in the IDLE cycle is ignored.
        man_ready = 1'b0; rst = 1'b1;
        tick(); check_reset("rst_req");
        rst = 1'b0; man_ready = 1'b1; man_rdata = 32'h0000_7777;
        tick(); check_req("rst_req_fetch", 1'b1, 32'h0); check_eq("rst_req_valid", 32'(bus.if_valid), 32'd0);
        man_rdata = 32'h0000_0010;
        tick(); check_slot("rst_req_slot", 32'h10, 32'h1); check_req("rst_req_next", 1'b1, 32'h1);

        // Reset while a word sits in the skid buffer.
        bus.freeze = 1'b1; man_rdata = 32'h0000_0011;
        tick(); check_req("skid_hold", 1'b0, 32'h0); check_slot("skid_hold", 32'h10, 32'h1);
        rst = 1'b1;
        tick(); check_reset("rst_skid");
        rst = 1'b0; bus.freeze = 1'b0; man_rdata = 32'h0000_0020;
        tick(); check_req("rst_skid_fetch", 1'b1, 32'h0); check_eq("rst_skid_valid", 32'(bus.if_valid), 32'd0);
        man_rdata = 32'h0000_0030;
        tick(); check_slot("rst_skid_slot", 32'h30, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
